// File: rtl/misr_signature_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : misr_signature_collector_if
// Description : Run-control and result bus of the MISR signature collector.
// Revision    : 1.0  initial release
// ============================================================================
interface misr_signature_collector_if #(
   parameter int IN_WIDTH  = 11,
   parameter int SIG_WIDTH = 32,
   parameter int CNT_WIDTH = 16
);
   logic                 start;
   logic [CNT_WIDTH-1:0] n_cycles;
   logic [IN_WIDTH-1:0]  data_in;
   logic [SIG_WIDTH-1:0] exp_sig;
   logic                 busy;
   logic                 done;
   logic [SIG_WIDTH-1:0] sig_out;
   logic                 pass;

   modport master (
      output start, n_cycles, data_in, exp_sig,
      input  busy, done, sig_out, pass
   );

   modport slave (
      input  start, n_cycles, data_in, exp_sig,
      output busy, done, sig_out, pass
   );
endinterface
`default_nettype wire

// File: rtl/misr_signature_collector.sv
`default_nettype none
// ============================================================================
// Module      : misr_signature_collector
// Description : Skips DUT latency, compacts N result words into a Galois MISR
//               and flags the final signature against an expected value.
// Revision    : 1.0  initial release
// ============================================================================
module misr_signature_collector #(
   parameter int                  IN_WIDTH  = 11,
   parameter int                  SIG_WIDTH = 32,
   parameter logic [SIG_WIDTH-1:0] POLY     = 32'h04C11DB7,
   parameter logic [SIG_WIDTH-1:0] SEED     = 32'hFFFFFFFF,
   parameter int                  LATENCY   = 2,
   parameter int                  CNT_WIDTH = 16
) (
   input  wire logic clk,
   input  wire logic resetn,
   misr_signature_collector_if.slave io_bus
);

   localparam int WCNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WARMUP  = 2'd1,
      S_COLLECT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   state_t               w_start_target;
   logic [CNT_WIDTH-1:0] r_ncnt;
   logic [WCNT_W-1:0]    r_wcnt;
   logic [SIG_WIDTH-1:0] r_sig;
   logic [SIG_WIDTH-1:0] w_sig_next;
   logic                 w_start_ok;

   assign w_start_ok = io_bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Galois step: shift, fold back the polynomial on carry-out, inject the word.
   assign w_sig_next = {r_sig[SIG_WIDTH-2:0], 1'b0}
                     ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
                     ^ SIG_WIDTH'(io_bus.data_in);

   always_comb begin
      w_start_target = S_DONE;
      if (LATENCY > 0) begin
         w_start_target = S_WARMUP;
      end else if (io_bus.n_cycles != '0) begin
         w_start_target = S_COLLECT;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (io_bus.start) begin
               w_next = w_start_target;
            end
         end
         S_WARMUP: begin
            if (r_wcnt <= WCNT_W'(1)) begin
               w_next = (r_ncnt == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (r_ncnt <= CNT_WIDTH'(1)) begin
               w_next = S_DONE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The signature only moves on an accepted start or while collecting, so
   // data_in is never sampled in any other state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sig  <= '0;
         r_ncnt <= '0;
         r_wcnt <= '0;
      end else if (w_start_ok) begin
         r_sig  <= SEED;
         r_ncnt <= io_bus.n_cycles;
         r_wcnt <= WCNT_W'(LATENCY);
      end else begin
         case (r_state)
            S_WARMUP: begin
               if (r_wcnt != '0) begin
                  r_wcnt <= r_wcnt - WCNT_W'(1);
               end
            end
            S_COLLECT: begin
               r_sig <= w_sig_next;
               if (r_ncnt != '0) begin
                  r_ncnt <= r_ncnt - CNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.busy    = (r_state == S_WARMUP) || (r_state == S_COLLECT);
   assign io_bus.done    = (r_state == S_DONE);
   assign io_bus.sig_out = r_sig;
   assign io_bus.pass    = (r_state == S_DONE) && (r_sig == io_bus.exp_sig);

endmodule
`default_nettype wire

// File: tb/tb_misr_signature_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_misr_signature_collector
// Description : Directed runs with a queue of expected signatures and done
//               latencies, popped by an independent done monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_misr_signature_collector;

   localparam int          L    = 2;
   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;

   typedef struct {
      logic [31:0] sig;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          chk = 0;
   int          err = 0;
   bit          done_q = 1'b0;
   exp_t        sb[$];
   logic [10:0] words[$];

   misr_signature_collector_if #(.IN_WIDTH(11), .SIG_WIDTH(32), .CNT_WIDTH(16)) bus ();

   misr_signature_collector #(
      .IN_WIDTH(11), .SIG_WIDTH(32), .POLY(POLY), .SEED(SEED),
      .LATENCY(L), .CNT_WIDTH(16)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      chk++;
      if (act !== req) begin
         err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference MISR over the word queue, written directly from the update equation.
   function automatic logic [31:0] model(input int n);
      logic [31:0] s = SEED;
      for (int k = 0; k < n; k++) begin
         s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {21'h0, words[k]};
      end
      return s;
   endfunction

   task automatic fill_lfsr(input int n);
      logic [15:0] l = 16'hACE1;
      logic        b;
      words.delete();
      for (int k = 0; k < n; k++) begin
         words.push_back(l[10:0]);
         b = l[0] ^ l[2] ^ l[3] ^ l[5];
         l = {b, l[15:1]};
      end
   endtask

   // Monitor: every rising done pops one expected signature and latency.
   always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
         done_q = 1'b0;
      end else begin
         if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
               chk++;
               err++;
               $display("FAIL unexpected_done: got done=1, expected no run pending");
            end else begin
               e = sb.pop_front();
               check("sig_out", bus.sig_out, e.sig);
               check("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
         end
         done_q = bus.done;
      end
   end

   task automatic run(input int n, input logic [31:0] exp_s, input bit glitch);
      int   lat;
      bit   seen;
      lat = (n == 0) ? ((L > 1) ? L : 1) : (L + n);
      sb.push_back('{sig: exp_s, lat: lat});
      bus.start    = 1'b1;
      bus.n_cycles = 16'(n);
      bus.data_in  = 11'h7FF;
      @(negedge clk);
      start_cyc    = cyc;
      bus.start    = 1'b0;
      check("seed_on_start", bus.sig_out, SEED);
      check("done_cleared", {31'h0, bus.done}, 32'h0);
      check("pass_cleared", {31'h0, bus.pass}, 32'h0);
      repeat (L) begin
         check("busy_warmup", {31'h0, bus.busy}, 32'h1);
         bus.data_in = 11'h2AA;
         @(negedge clk);
      end
      for (int k = 0; k < n; k++) begin
         check("busy_collect", {31'h0, bus.busy}, 32'h1);
         bus.data_in = words[k];
         if (glitch && k == 1) begin
            bus.start    = 1'b1;
            bus.n_cycles = 16'd7;
         end else begin
            bus.start    = 1'b0;
            bus.n_cycles = 16'(n);
         end
         @(negedge clk);
      end
      bus.start   = 1'b0;
      bus.data_in = 11'h555;
      seen = bus.done;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus.done;
      end
      if (!seen) begin
         chk++;
         err++;
         $display("FAIL done_timeout: got done=0, expected done=1");
      end
      check("busy_after_done", {31'h0, bus.busy}, 32'h0);
      bus.exp_sig = exp_s;
      #1;
      check("pass_match", {31'h0, bus.pass}, 32'h1);
      bus.exp_sig = ~exp_s;
      #1;
      check("pass_mismatch", {31'h0, bus.pass}, 32'h0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.n_cycles = '0;
      bus.data_in  = '0;
      bus.exp_sig  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'h0, bus.busy}, 32'h0);
      check("rst_done", {31'h0, bus.done}, 32'h0);
      check("rst_sig", bus.sig_out, 32'h0);
      check("rst_pass", {31'h0, bus.pass}, 32'h0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      words = '{11'h001};
      run(1, 32'hFB3EE248, 1'b0);

      words = '{11'h001, 11'h002};
      run(2, 32'hF2BCD925, 1'b0);

      run(0, 32'hFFFFFFFF, 1'b0);

      words = '{11'h7FF, 11'h123, 11'h456, 11'h000};
      run(4, model(4), 1'b1);

      fill_lfsr(1000);
      run(1000, model(1000), 1'b0);
      repeat (5) @(negedge clk);
      check("done_held", {31'h0, bus.done}, 32'h1);
      check("sig_frozen", bus.sig_out, model(1000));
      run(1000, model(1000), 1'b0);

      // Asynchronous reset in the middle of a collect phase.
      words = '{11'h011, 11'h022, 11'h033, 11'h044, 11'h055, 11'h066, 11'h077, 11'h088};
      bus.start    = 1'b1;
      bus.n_cycles = 16'd8;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (L + 3) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("midrun_busy", {31'h0, bus.busy}, 32'h0);
      check("midrun_done", {31'h0, bus.done}, 32'h0);
      check("midrun_sig", bus.sig_out, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_busy", {31'h0, bus.busy}, 32'h0);
      check("idle_done", {31'h0, bus.done}, 32'h0);
      check("idle_sig", bus.sig_out, 32'h0);

      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
